// File: rtl/mem_access_arbiter.sv
// Two-client round-robin controller for the single-port Memory block; all outputs registered.
// Define MEMARB_FIXED_PRIORITY_EN to make client 0 always win contention.
module mem_access_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int WDATA_W = 11,
    parameter int RDATA_W = 12,
    parameter int DEPTH   = 101
) (
    input  logic               MCLK,
    input  logic               RST_N,
    input  logic               REQ0,
    input  logic               REQ1,
    input  logic               WE0,
    input  logic               WE1,
    input  logic [ADDR_W-1:0]  ADDR0,
    input  logic [ADDR_W-1:0]  ADDR1,
    input  logic [WDATA_W-1:0] WDATA0,
    input  logic [WDATA_W-1:0] WDATA1,
    output logic               GNT0,
    output logic               GNT1,
    output logic               RVALID0,
    output logic               RVALID1,
    output logic               ERR0,
    output logic               ERR1,
    output logic [RDATA_W-1:0] RDATA,
    output logic               BUSY,
    output logic               MemWriteEn,
    output logic               MemReadEn,
    output logic [ADDR_W-1:0]  MemWAddress,
    output logic [ADDR_W-1:0]  MemRAddress,
    output logic [WDATA_W-1:0] MemInData,
    input  logic [RDATA_W-1:0] MemOutData
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    typedef struct packed {
        logic               id;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } req_t;

    state_t state, state_nx;
    req_t   cur, cur_nx;
    logic   last, last_nx;      // client granted most recently
    logic   win;

    logic [1:0]         gnt_q, gnt_nx, err_q, err_nx, rv_q, rv_nx;
    logic [RDATA_W-1:0] rdata_nx;
    logic               busy_nx, wen_nx, ren_nx;
    logic [ADDR_W-1:0]  waddr_nx, raddr_nx;
    logic [WDATA_W-1:0] wdat_nx;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH);
    endfunction

`ifdef MEMARB_FIXED_PRIORITY_EN
    assign win = !REQ0;
`else
    assign win = (REQ0 && REQ1) ? !last : !REQ0;
`endif

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        last_nx  = last;
        gnt_nx   = '0;
        err_nx   = '0;
        rv_nx    = '0;
        rdata_nx = RDATA;
        wen_nx   = 1'b0;
        ren_nx   = 1'b0;
        waddr_nx = MemWAddress;
        raddr_nx = MemRAddress;
        wdat_nx  = MemInData;
        unique case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    cur_nx.id    = win;
                    cur_nx.we    = win ? WE1 : WE0;
                    cur_nx.addr  = win ? ADDR1 : ADDR0;
                    cur_nx.wdata = win ? WDATA1 : WDATA0;
                    last_nx      = win;
                    gnt_nx[win]  = 1'b1;
                    state_nx     = ISSUE;
                    // Enables are decided here so they appear in the ISSUE cycle itself
                    if (!in_range(cur_nx.addr)) begin
                        err_nx[win] = 1'b1;
                    end else if (cur_nx.we) begin
                        wen_nx   = 1'b1;
                        waddr_nx = cur_nx.addr;
                        wdat_nx  = cur_nx.wdata;
                    end else begin
                        ren_nx   = 1'b1;
                        raddr_nx = cur_nx.addr;
                    end
                end
            end
            ISSUE: begin
                state_nx = IDLE;
                if (!cur.we) begin
                    if (in_range(cur.addr)) begin
                        state_nx = RDWAIT;
                    end else begin
                        rv_nx[cur.id] = 1'b1;
                        rdata_nx      = '0;
                    end
                end
            end
            RDWAIT: begin
                rdata_nx      = MemOutData;
                rv_nx[cur.id] = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cur         <= '0;
            last        <= 1'b1;
            gnt_q       <= '0;
            err_q       <= '0;
            rv_q        <= '0;
            RDATA       <= '0;
            BUSY        <= 1'b0;
            MemWriteEn  <= 1'b0;
            MemReadEn   <= 1'b0;
            MemWAddress <= '0;
            MemRAddress <= '0;
            MemInData   <= '0;
        end else begin
            state       <= state_nx;
            cur         <= cur_nx;
            last        <= last_nx;
            gnt_q       <= gnt_nx;
            err_q       <= err_nx;
            rv_q        <= rv_nx;
            RDATA       <= rdata_nx;
            BUSY        <= busy_nx;
            MemWriteEn  <= wen_nx;
            MemReadEn   <= ren_nx;
            MemWAddress <= waddr_nx;
            MemRAddress <= raddr_nx;
            MemInData   <= wdat_nx;
        end
    end

    assign GNT0    = gnt_q[0];
    assign GNT1    = gnt_q[1];
    assign ERR0    = err_q[0];
    assign ERR1    = err_q[1];
    assign RVALID0 = rv_q[0];
    assign RVALID1 = rv_q[1];

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural Memory stub and a transaction-level model.
module tb_mem_access_arbiter;
    localparam int ADDR_W = 11, WDATA_W = 11, RDATA_W = 12, DEPTH = 101;

    logic MCLK = 1'b0, RST_N = 1'b1;
    logic REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0;
    logic [ADDR_W-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [WDATA_W-1:0] WDATA0 = '0, WDATA1 = '0;
    logic GNT0, GNT1, RVALID0, RVALID1, ERR0, ERR1, BUSY, MemWriteEn, MemReadEn;
    logic [RDATA_W-1:0] RDATA;
    logic [RDATA_W-1:0] MemOutData = '0;
    logic [ADDR_W-1:0] MemWAddress, MemRAddress;
    logic [WDATA_W-1:0] MemInData;

    mem_access_arbiter dut (
        .MCLK(MCLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .ERR0(ERR0), .ERR1(ERR1), .RDATA(RDATA), .BUSY(BUSY),
        .MemWriteEn(MemWriteEn), .MemReadEn(MemReadEn), .MemWAddress(MemWAddress),
        .MemRAddress(MemRAddress), .MemInData(MemInData), .MemOutData(MemOutData));

    always #5 MCLK = ~MCLK;

    // Memory stub: synchronous read, data valid the cycle after ReadEn
    logic [RDATA_W-1:0] mem [DEPTH];
    always @(posedge MCLK) begin
        if (MemWriteEn && MemWAddress < DEPTH) mem[MemWAddress] = {1'b0, MemInData};
        if (MemReadEn && MemRAddress < DEPTH) MemOutData <= mem[MemRAddress];
    end

    typedef struct { logic id; logic we; logic [ADDR_W-1:0] addr; logic [WDATA_W-1:0] wdata; logic bad; } gexp_t;
    typedef struct { logic id; logic [RDATA_W-1:0] data; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    int cq[$];
    int errors = 0, checks = 0, cyc = 0;

    logic [RDATA_W-1:0] ref_mem [DEPTH];
    logic ref_last = 1'b1;
    logic req_we [2];
    logic [ADDR_W-1:0] req_a [2];
    logic [WDATA_W-1:0] req_d [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or read data
    gexp_t g;
    rexp_t r;
    int ec;
    always @(negedge MCLK) begin
        cyc++;
        if (RST_N) begin
            chk("we_re_excl", 32'(MemWriteEn && MemReadEn), 0);
            chk("gnt_excl", 32'(GNT0 && GNT1), 0);
            chk("err_wo_gnt", 32'((ERR0 && !GNT0) || (ERR1 && !GNT1)), 0);
            if (GNT0 || GNT1) begin
                if (gq.size() == 0) chk("unexpected_gnt", 1, 0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_id", 32'(GNT1), 32'(g.id));
                    chk("busy_in_issue", 32'(BUSY), 1);
                    chk("err", {30'b0, ERR1, ERR0}, g.bad ? (g.id ? 2 : 1) : 0);
                    chk("wen", 32'(MemWriteEn), 32'(g.we && !g.bad));
                    chk("ren", 32'(MemReadEn), 32'(!g.we && !g.bad));
                    if (g.we && !g.bad) begin
                        chk("waddr", 32'(MemWAddress), 32'(g.addr));
                        chk("wdata", 32'(MemInData), 32'(g.wdata));
                    end
                    if (!g.we && !g.bad) chk("raddr", 32'(MemRAddress), 32'(g.addr));
                    if (!g.we) cq.push_back(cyc + (g.bad ? 1 : 2));
                end
            end
            if (RVALID0 || RVALID1) begin
                chk("rv_excl", 32'(RVALID0 && RVALID1), 0);
                if (rq.size() == 0 || cq.size() == 0) chk("unexpected_rvalid", 1, 0);
                else begin
                    r = rq.pop_front();
                    ec = cq.pop_front();
                    chk("rv_id", 32'(RVALID1), 32'(r.id));
                    chk("rdata", 32'(RDATA), 32'(r.data));
                    chk("rv_latency", cyc, ec);
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic we, input logic [ADDR_W-1:0] a, input logic [WDATA_W-1:0] d);
        req_we[id] = we; req_a[id] = a; req_d[id] = d;
        if (id) begin WE1 = we; ADDR1 = a; WDATA1 = d; end
        else begin WE0 = we; ADDR0 = a; WDATA0 = d; end
    endtask

    // Transaction-level model: one access applied to the reference memory per grant
    task automatic push_exp(input logic id);
        gexp_t e;
        rexp_t x;
        e.id = id; e.we = req_we[id]; e.addr = req_a[id]; e.wdata = req_d[id];
        e.bad = (int'(req_a[id]) >= DEPTH);
        gq.push_back(e);
        if (!e.we) begin
            x.id = id;
            x.data = e.bad ? '0 : ref_mem[e.addr];
            rq.push_back(x);
        end else if (!e.bad) ref_mem[e.addr] = {1'b0, e.wdata};
        ref_last = id;
    endtask

    function automatic logic first_of_both();
`ifdef MEMARB_FIXED_PRIORITY_EN
        return 1'b0;
`else
        return !ref_last;
`endif
    endfunction

    task automatic expect_round(input bit r0, input bit r1);
        logic f;
        if (r0 && r1) begin
            f = first_of_both();
            push_exp(f);
            push_exp(!f);
        end else push_exp(r1 ? 1'b1 : 1'b0);
    endtask

    task automatic run(input bit r0, input bit r1, input int ngr, input bit hold);
        int n = 0, t = 0;
        REQ0 = r0; REQ1 = r1;
        while (n < ngr && t < 60) begin
            @(negedge MCLK); t++;
            if (GNT0) begin n++; if (!hold) REQ0 = 0; end
            if (GNT1) begin n++; if (!hold) REQ1 = 0; end
        end
        REQ0 = 0; REQ1 = 0;
        chk("grant_count", n, ngr);
    endtask

    task automatic drain();
        int t = 0;
        while ((gq.size() != 0 || rq.size() != 0) && t < 40) begin @(negedge MCLK); t++; end
        chk("drain", gq.size() + rq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        #2 RST_N = 0;
        repeat (2) @(negedge MCLK);
        chk("rst_outs", {GNT0, GNT1, RVALID0, RVALID1, ERR0, ERR1, BUSY, MemWriteEn, MemReadEn}, 0);
        chk("rst_rdata", 32'(RDATA), 0);
        chk("rst_maddr", {MemWAddress, MemRAddress}, 0);
        RST_N = 1;
        @(negedge MCLK);

        // Write 5 <- 2A5, then read it back
        set_req(0, 1, 11'd5, 11'h2A5); expect_round(1, 0); run(1, 0, 1, 0);
        @(negedge MCLK);
        chk("busy_after_write", 32'(BUSY), 0);
        set_req(0, 0, 11'd5, 11'h0); expect_round(1, 0); run(1, 0, 1, 0); drain();

        // Illegal read by client 1
        set_req(1, 0, 11'd101, 11'h0); expect_round(0, 1); run(0, 1, 1, 0); drain();

        // Both held for four grants
        set_req(0, 1, 11'd10, 11'h111); set_req(1, 1, 11'd11, 11'h222);
        for (int k = 0; k < 4; k++) push_exp(first_of_both());
        run(1, 1, 4, 1); drain();

        // Top legal address, then an out-of-range write
        set_req(0, 1, 11'd100, 11'h5A5); expect_round(1, 0); run(1, 0, 1, 0);
        set_req(1, 0, 11'd100, 11'h0); expect_round(0, 1); run(0, 1, 1, 0); drain();
        set_req(1, 1, 11'd2047, 11'h7FF); expect_round(0, 1); run(0, 1, 1, 0);
        set_req(0, 0, 11'd100, 11'h0); expect_round(1, 0); run(1, 0, 1, 0); drain();

        // Reset while the read sits in RDWAIT
        set_req(0, 0, 11'd7, 11'h0); expect_round(1, 0); run(1, 0, 1, 0);
        @(posedge MCLK); #1;
        RST_N = 0; #1;
        chk("midrst_outs", {GNT0, GNT1, RVALID0, RVALID1, ERR0, ERR1, BUSY, MemWriteEn, MemReadEn}, 0);
        chk("midrst_rdata", 32'(RDATA), 0);
        gq.delete(); rq.delete(); cq.delete();
        ref_last = 1'b1;
        @(negedge MCLK); RST_N = 1;
        repeat (5) @(negedge MCLK);
        set_req(1, 1, 11'd7, 11'h3C3); set_req(0, 0, 11'd7, 11'h0);
        expect_round(1, 1); run(1, 1, 2, 0); drain();

        // Randomized rounds
        for (int it = 0; it < 80; it++) begin
            int m;
            m = $urandom_range(1, 3);
            for (int c = 0; c < 2; c++) begin
                logic [ADDR_W-1:0] a;
                if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(DEPTH, 2047));
                else if ($urandom_range(0, 1) == 0) a = ADDR_W'($urandom_range(0, 7));
                else a = ADDR_W'($urandom_range(0, DEPTH - 1));
                set_req(c[0], $urandom_range(0, 1) == 1, a, WDATA_W'($urandom));
            end
            expect_round(m[0], m[1]);
            run(m[0], m[1], m[0] + m[1], 0);
            repeat ($urandom_range(0, 2)) @(negedge MCLK);
        end
        drain();
        repeat (3) @(negedge MCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
